// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types and constants used by the fetch stage
package mips_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/response port
interface if_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_pc_next_sel.sv
// rtl/if_fetch_stage_pc_next_sel.sv - next-PC mux (branch > jump > sequential > hold) with target alignment check
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] target;

  assign redirect   = branch_taken | jump;
  assign target     = branch_taken ? branch_target : jump_target;
  assign pc_plus4   = pc + 32'd4;
  assign misaligned = redirect && (target[1:0] != 2'b00);

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = target & WORD_ALIGN_MASK;
    end else if (advance) begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - IF stage: PC ownership, single-outstanding imem fetch, stall hold and redirect drain
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hazard,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  input  logic                    jump,
  input  logic [31:0]             jump_target,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             pc_plus4_out,
  output logic [31:0]             instr_out,
  output logic                    fetch_valid,
  output logic                    misalign_err
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  hold_buf;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         misaligned;
  logic         deliver;
  logic         capture;
  logic         advance;

  assign advance = deliver && !hazard;

  pc_next_sel u_pc_next_sel (
    .pc            (pc),
    .advance       (advance),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .redirect      (redirect),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= REQ;
      pc           <= RESET_PC;
      hold_buf     <= NOP_INSTR;
      misalign_err <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= next_pc;
      if (capture) begin
        hold_buf <= imem.imem_rdata;
      end else if (redirect) begin
        hold_buf <= NOP_INSTR;
      end
      if (misaligned) begin
        misalign_err <= 1'b1;
      end
    end
  end

  // A redirect always suppresses delivery: IF/ID is being flushed this cycle.
  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    capture    = 1'b0;
    case (state)
      REQ: begin
        if (imem.imem_ready) begin
          state_next = redirect ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect) begin
            state_next = REQ;
          end else begin
            deliver = 1'b1;
            if (hazard) begin
              capture    = 1'b1;
              state_next = HOLD;
            end else begin
              state_next = REQ;
            end
          end
        end else if (redirect) begin
          state_next = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_next = REQ;
        end else begin
          deliver = 1'b1;
          if (!hazard) begin
            state_next = REQ;
          end
        end
      end
      DRAIN: begin
        // The stale response retires the outstanding request, redirected or not.
        if (imem.imem_rvalid) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
    if (reset) begin
      deliver = 1'b0;
      capture = 1'b0;
    end
  end

  assign imem.imem_req  = !reset && (state == REQ);
  assign imem.imem_addr = pc & WORD_ALIGN_MASK;

  assign fetch_valid  = deliver;
  assign pc_plus4_out = deliver ? pc_plus4 : 32'h0000_0000;
  assign instr_out    = !deliver        ? NOP_INSTR :
                        (state == HOLD) ? hold_buf  : imem.imem_rdata;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage with a transaction-level reference model
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic        fetch_valid;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem          (imem_bus),
    .pc_plus4_out  (pc_plus4_out),
    .instr_out     (instr_out),
    .fetch_valid   (fetch_valid),
    .misalign_err  (misalign_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage either owns an outstanding request (possibly doomed),
  // holds a stalled instruction, or is free to request at m_pc.
  logic [31:0] m_pc        = 32'h0;
  bit          m_out       = 1'b0;
  bit          m_discard   = 1'b0;
  bit          m_held      = 1'b0;
  logic [31:0] m_hold_data = 32'h0;
  bit          m_err       = 1'b0;

  always @(posedge clk) begin : model_update
    bit          redir;
    bit          may_req;
    logic [31:0] tgt;
    redir   = branch_taken | jump;
    tgt     = branch_taken ? branch_target : jump_target;
    may_req = !m_out && !m_held;
    if (reset) begin
      m_pc = 32'h0; m_out = 0; m_discard = 0; m_held = 0; m_hold_data = 32'h0; m_err = 0;
    end else if (redir) begin
      m_pc   = {tgt[31:2], 2'b00};
      m_err  = m_err | (tgt[1:0] != 2'b00);
      m_held = 0;
      if (m_out) begin
        if (imem_bus.imem_rvalid) m_out = 0;
        else m_discard = 1;
      end else if (may_req && imem_bus.imem_ready) begin
        m_out = 1; m_discard = 1;
      end
    end else if (may_req) begin
      if (imem_bus.imem_ready) begin m_out = 1; m_discard = 0; end
    end else if (m_out) begin
      if (imem_bus.imem_rvalid) begin
        m_out = 0;
        if (!m_discard) begin
          if (hazard) begin m_held = 1; m_hold_data = imem_bus.imem_rdata; end
          else m_pc = m_pc + 32'd4;
        end
        m_discard = 0;
      end
    end else if (m_held && !hazard) begin
      m_held = 0;
      m_pc   = m_pc + 32'd4;
    end
  end

  bit          acc_was;
  bit          rv_was;
  logic [31:0] addr_was;

  always @(negedge clk) begin : compare
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] exp_instr;
    exp_req   = !reset && !m_out && !m_held;
    exp_valid = 0;
    exp_instr = 32'h0;
    if (!reset && !(branch_taken | jump)) begin
      if (m_held) begin
        exp_valid = 1; exp_instr = m_hold_data;
      end else if (m_out && !m_discard && imem_bus.imem_rvalid) begin
        exp_valid = 1; exp_instr = imem_bus.imem_rdata;
      end
    end
    check("imem_req", {31'h0, imem_bus.imem_req}, {31'h0, exp_req});
    if (exp_req) check("imem_addr", imem_bus.imem_addr, m_pc);
    check("fetch_valid", {31'h0, fetch_valid}, {31'h0, exp_valid});
    check("pc_plus4_out", pc_plus4_out, exp_valid ? m_pc + 32'd4 : 32'h0);
    check("instr_out", instr_out, exp_instr);
    check("misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
    acc_was  = imem_bus.imem_req && imem_bus.imem_ready;
    rv_was   = imem_bus.imem_rvalid;
    addr_was = imem_bus.imem_addr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  bit          mem_pending = 0;
  int          mem_cnt     = 0;
  logic [31:0] mem_addr    = 32'h0;

  task automatic auto_step();
    cyc();
    if (mem_pending && rv_was) mem_pending = 0;
    if (acc_was) begin
      mem_pending = 1;
      mem_cnt     = $urandom_range(0, 2);
      mem_addr    = addr_was;
    end
    if (mem_pending && mem_cnt == 0) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = mem_word(mem_addr);
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = $urandom;
      if (mem_pending) mem_cnt--;
    end
    imem_bus.imem_ready = !mem_pending && ($urandom_range(0, 3) != 0);
    hazard        = ($urandom_range(0, 9) < 3);
    branch_taken  = ($urandom_range(0, 19) == 0);
    jump          = ($urandom_range(0, 19) == 0);
    branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom & 32'hFFFF_FFFD;
    jump_target   = ($urandom_range(0, 1) == 0) ? $urandom : $urandom & 32'hFFFF_FFFC;
    reset         = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    reset = 1; hazard = 0; branch_taken = 0; jump = 0;
    branch_target = 32'h0; jump_target = 32'h0;
    imem_bus.imem_ready = 0; imem_bus.imem_rvalid = 0; imem_bus.imem_rdata = 32'h0;
    cyc(); cyc(); #1;
    check("rst_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("rst_valid", {31'h0, fetch_valid}, 32'h0);
    check("rst_pc4", pc_plus4_out, 32'h0);
    check("rst_instr", instr_out, 32'h0);

    // Two back-to-back fetches with a 1-cycle memory
    cyc(); reset = 0; imem_bus.imem_ready = 1; #1;
    check("s1_req", {31'h0, imem_bus.imem_req}, 32'h1);
    check("s1_addr0", imem_bus.imem_addr, 32'h0);
    cyc(); imem_bus.imem_ready = 0; imem_bus.imem_rvalid = 1; imem_bus.imem_rdata = 32'h2008_0005; #1;
    check("s1_valid0", {31'h0, fetch_valid}, 32'h1);
    check("s1_pc4_0", pc_plus4_out, 32'h4);
    check("s1_instr0", instr_out, 32'h2008_0005);
    cyc(); imem_bus.imem_rvalid = 0; imem_bus.imem_ready = 1; #1;
    check("s1_bubble_valid", {31'h0, fetch_valid}, 32'h0);
    check("s1_bubble_pc4", pc_plus4_out, 32'h0);
    check("s1_bubble_instr", instr_out, 32'h0);
    check("s1_addr4", imem_bus.imem_addr, 32'h4);
    cyc(); imem_bus.imem_ready = 0; imem_bus.imem_rvalid = 1; imem_bus.imem_rdata = 32'h2009_0003; #1;
    check("s1_pc4_1", pc_plus4_out, 32'h8);
    check("s1_instr1", instr_out, 32'h2009_0003);

    // Hazard spanning the response: four delivery cycles of the same word
    cyc(); imem_bus.imem_rvalid = 0; imem_bus.imem_ready = 1; #1;
    check("s2_addr8", imem_bus.imem_addr, 32'h8);
    cyc(); imem_bus.imem_ready = 0; imem_bus.imem_rvalid = 1; imem_bus.imem_rdata = 32'h1111_2222; hazard = 1; #1;
    check("s2_instr_a", instr_out, 32'h1111_2222);
    cyc(); imem_bus.imem_rvalid = 0; imem_bus.imem_rdata = 32'h0; #1;
    check("s2_instr_b", instr_out, 32'h1111_2222);
    check("s2_hold_req", {31'h0, imem_bus.imem_req}, 32'h0);
    cyc(); #1;
    check("s2_instr_c", instr_out, 32'h1111_2222);
    cyc(); hazard = 0; #1;
    check("s2_valid_d", {31'h0, fetch_valid}, 32'h1);
    check("s2_pc4_d", pc_plus4_out, 32'hC);
    cyc(); imem_bus.imem_ready = 1; #1;
    check("s2_addr12", imem_bus.imem_addr, 32'hC);

    // Branch while waiting: the late response must be discarded
    cyc(); imem_bus.imem_ready = 0; branch_taken = 1; branch_target = 32'h40; #1;
    check("s3_redir_valid", {31'h0, fetch_valid}, 32'h0);
    cyc(); branch_taken = 0; imem_bus.imem_rvalid = 1; imem_bus.imem_rdata = 32'hDEAD_BEEF; #1;
    check("s3_drain_valid", {31'h0, fetch_valid}, 32'h0);
    cyc(); imem_bus.imem_rvalid = 0; #1;
    check("s3_addr40", imem_bus.imem_addr, 32'h40);

    // Branch beats jump
    branch_taken = 1; branch_target = 32'h80; jump = 1; jump_target = 32'hC0;
    cyc(); branch_taken = 0; jump = 0; #1;
    check("s4_addr80", imem_bus.imem_addr, 32'h80);
    check("s4_err", {31'h0, misalign_err}, 32'h0);

    // Misaligned jump target is truncated and flagged stickily
    jump = 1; jump_target = 32'h0000_0102;
    cyc(); jump = 0; #1;
    check("s5_addr100", imem_bus.imem_addr, 32'h100);
    check("s5_err", {31'h0, misalign_err}, 32'h1);
    check("s5_model_pc", m_pc, 32'h100);
    imem_bus.imem_ready = 1;
    cyc(); imem_bus.imem_ready = 0; #1;
    check("s5_err_sticky", {31'h0, misalign_err}, 32'h1);

    // Reset in WAIT, response arrives the cycle after
    reset = 1; #1;
    check("s6_rst_req", {31'h0, imem_bus.imem_req}, 32'h0);
    check("s6_rst_valid", {31'h0, fetch_valid}, 32'h0);
    check("s6_rst_pc4", pc_plus4_out, 32'h0);
    check("s6_rst_instr", instr_out, 32'h0);
    cyc(); reset = 0; imem_bus.imem_rvalid = 1; imem_bus.imem_rdata = 32'hDEAD_BEEF; #1;
    check("s6_ignored", {31'h0, fetch_valid}, 32'h0);
    check("s6_addr_reset", imem_bus.imem_addr, 32'h0);
    check("s6_err_clr", {31'h0, misalign_err}, 32'h0);
    cyc(); imem_bus.imem_rvalid = 0; imem_bus.imem_rdata = 32'h0;

    repeat (4000) auto_step();
    reset = 0; branch_taken = 0; jump = 0; hazard = 0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
